// File: rtl/fx2_pkg.sv
// Shared definitions for the FX2 FPGA-word source: command codes, reply
// constants and the output-register state type.
package fx2_pkg;

  localparam logic [4:0] CMD_START  = 5'd1;
  localparam logic [4:0] CMD_STOP   = 5'd2;
  localparam logic [4:0] CMD_FLUSH  = 5'd3;
  localparam logic [4:0] CMD_PING   = 5'd4;
  localparam logic [4:0] CMD_STATUS = 5'd5;
  localparam logic [4:0] CMD_OVF    = 5'd6;

  localparam logic [7:0] PING_BYTE = 8'hA5;

  typedef enum logic {
    OUT_EMPTY  = 1'b0,
    OUT_LOADED = 1'b1
  } out_state_t;

  // Saturate a fill level into the 7-bit field of the STATUS reply.
  function automatic logic [6:0] sat7(input logic [31:0] v);
    return (v > 32'd127) ? 7'd127 : v[6:0];
  endfunction

endpackage

// File: rtl/fx2_sync_fifo.sv
// DEPTH x 8 synchronous FIFO with synchronous clear and fill count.
// A write while full is accepted only when a read happens in the same cycle.
module fx2_sync_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    count   = count_q;
    rd_data = mem[rd_ptr_q];
    do_rd   = rd_en && !empty;
    do_wr   = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_wr && !do_rd) count_d = count_q + CW'(1);
      else if (do_rd && !do_wr) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fx2_word_source.sv
// Buffers samples and offers them byte-wise to the FX2 bridge, decoding PC commands.
// Define FX2_WORD_SOURCE_OVF_EN to add the dropped-sample counter and command 6 (OVF).
module fx2_word_source
  import fx2_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic       FX2_CLK,
  input  logic       FX2_RST_N,
  input  logic [7:0] SAMPLE_DATA,
  input  logic       SAMPLE_STROBE,
  input  logic [7:0] PCINSTRUCTION,
  output logic [7:0] FPGA_WORD,
  output logic       FPGA_WORD_AVAILIABLE,
  input  logic       FPGA_WORD_ACCEPTED,
  output logic       STREAMING
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  out_state_t    state_q, state_d;
  logic [7:0]    word_q, word_d, reply_q, reply_d;
  logic          reply_valid_q, reply_valid_d;
  logic          streaming_q, streaming_d;
  logic [4:0]    cmd;
  logic          cmd_flush, reply_cmd, accept, can_load, load_reply;
  logic          fifo_rd, fifo_wr, fifo_full, fifo_empty;
  logic [7:0]    reply_byte, fifo_rd_data;
  logic [CW-1:0] fifo_count;
  logic          unused_dbg;
`ifdef FX2_WORD_SOURCE_OVF_EN
  logic [7:0]    ovf_q, ovf_d;
  logic          drop;
`endif

  fx2_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (FX2_CLK),
    .rst_n   (FX2_RST_N),
    .clr     (cmd_flush),
    .wr_en   (fifo_wr),
    .wr_data (SAMPLE_DATA),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    cmd        = PCINSTRUCTION[4:0];
    unused_dbg = ^PCINSTRUCTION[7:5];
    cmd_flush  = (cmd == CMD_FLUSH);
    reply_cmd  = 1'b0;
    reply_byte = '0;
    case (cmd)
      CMD_PING: begin
        reply_cmd  = 1'b1;
        reply_byte = PING_BYTE;
      end
      CMD_STATUS: begin
        reply_cmd  = 1'b1;
        reply_byte = {streaming_q, sat7(32'(fifo_count))};
      end
`ifdef FX2_WORD_SOURCE_OVF_EN
      CMD_OVF: begin
        reply_cmd  = 1'b1;
        reply_byte = ovf_q;
      end
`endif
      default: ;
    endcase
  end

  // An accept frees the register before the command applies; FLUSH suppresses the reload.
  always_comb begin
    accept     = FPGA_WORD_ACCEPTED && (state_q == OUT_LOADED);
    can_load   = ((state_q == OUT_EMPTY) || accept) && !cmd_flush;
    load_reply = can_load && reply_valid_q;
    fifo_rd    = can_load && !reply_valid_q && !fifo_empty;
    fifo_wr    = SAMPLE_STROBE && streaming_q && !cmd_flush;

    state_d = state_q;
    word_d  = word_q;
    if (cmd_flush) begin
      state_d = OUT_EMPTY;
    end else if (load_reply) begin
      state_d = OUT_LOADED;
      word_d  = reply_q;
    end else if (fifo_rd) begin
      state_d = OUT_LOADED;
      word_d  = fifo_rd_data;
    end else if (accept) begin
      state_d = OUT_EMPTY;
    end

    reply_valid_d = reply_valid_q && !load_reply;
    reply_d       = reply_q;
    if (reply_cmd && !reply_valid_q) begin
      reply_valid_d = 1'b1;
      reply_d       = reply_byte;
    end

    streaming_d = streaming_q;
    if (cmd == CMD_START) streaming_d = 1'b1;
    if (cmd == CMD_STOP)  streaming_d = 1'b0;

`ifdef FX2_WORD_SOURCE_OVF_EN
    drop  = fifo_wr && fifo_full && !fifo_rd;
    ovf_d = (cmd == CMD_OVF) ? '0 : ovf_q;
    if (drop && (ovf_d != '1)) ovf_d = ovf_d + 8'd1;
`endif
  end

  always_ff @(posedge FX2_CLK or negedge FX2_RST_N) begin
    if (!FX2_RST_N) begin
      state_q       <= OUT_EMPTY;
      word_q        <= '0;
      reply_q       <= '0;
      reply_valid_q <= 1'b0;
      streaming_q   <= 1'b0;
`ifdef FX2_WORD_SOURCE_OVF_EN
      ovf_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      reply_q       <= reply_d;
      reply_valid_q <= reply_valid_d;
      streaming_q   <= streaming_d;
`ifdef FX2_WORD_SOURCE_OVF_EN
      ovf_q         <= ovf_d;
`endif
    end
  end

  always_comb begin
    FPGA_WORD            = word_q;
    FPGA_WORD_AVAILIABLE = (state_q == OUT_LOADED);
    STREAMING            = streaming_q;
  end

endmodule

// File: tb/tb_fx2_word_source.sv
// Directed self-checking bench for fx2_word_source (DEPTH=16).
// OVF expectations follow FX2_WORD_SOURCE_OVF_EN when it is defined for the build.
module tb_fx2_word_source;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sample_data;
  logic       sample_strobe;
  logic [7:0] pcinstr;
  logic [7:0] word;
  logic       avail;
  logic       accepted;
  logic       streaming;

  int checks = 0;
  int fails  = 0;

  fx2_word_source #(.DEPTH(16)) dut (
    .FX2_CLK              (clk),
    .FX2_RST_N            (rst_n),
    .SAMPLE_DATA          (sample_data),
    .SAMPLE_STROBE        (sample_strobe),
    .PCINSTRUCTION        (pcinstr),
    .FPGA_WORD            (word),
    .FPGA_WORD_AVAILIABLE (avail),
    .FPGA_WORD_ACCEPTED   (accepted),
    .STREAMING            (streaming)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [7:0] exp);
    chk({tag, "_avail"}, {7'd0, avail}, 8'h01);
    chk({tag, "_word"}, word, exp);
  endtask

  initial begin
    rst_n = 1'b0; sample_data = '0; sample_strobe = 1'b0; pcinstr = '0; accepted = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    chk("rst_avail", {7'd0, avail}, 8'h00);
    chk("rst_word", word, 8'h00);
    chk("rst_streaming", {7'd0, streaming}, 8'h00);

    // strobes ignored while not streaming
    sample_strobe = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample_data = 8'h60 + 8'(i);
      chk("idle_avail", {7'd0, avail}, 8'h00);
      tick();
    end
    sample_strobe = 1'b0;
    pcinstr = 8'd5; tick(); pcinstr = '0; tick();
    chk_word("idle_status", 8'h00);
    accepted = 1'b1; tick(); accepted = 1'b0;
    chk("idle_status_gone", {7'd0, avail}, 8'h00);

    // START with debug bits set in [7:5], then streaming under continuous accept
    pcinstr = 8'hE1; tick(); pcinstr = '0;
    chk("start_streaming", {7'd0, streaming}, 8'h01);
    accepted = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sample_strobe = (i < 4);
      sample_data   = 8'h10 + 8'(i);
      if (i >= 2 && i <= 5) chk_word("stream", 8'h10 + 8'(i - 2));
      else chk("stream_idle", {7'd0, avail}, 8'h00);
      tick();
    end
    sample_strobe = 1'b0; accepted = 1'b0;

    // 20 strobes, no accepts: 1 in output, 16 in FIFO, 3 dropped
    sample_strobe = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample_data = 8'h20 + 8'(i);
      tick();
    end
    sample_strobe = 1'b0;
    tick();
    chk_word("ovf_hold0", 8'h20);
    pcinstr = 8'd6; tick(); pcinstr = '0;
    chk_word("ovf_hold1", 8'h20);
    accepted = 1'b1; tick();
`ifdef FX2_WORD_SOURCE_OVF_EN
    chk_word("ovf_reply", 8'h03);
    tick();
`endif
    chk_word("ovf_fifo0", 8'h21);
    tick();
    chk_word("ovf_fifo1", 8'h22);
    accepted = 1'b0;
    pcinstr = 8'd3; tick(); pcinstr = '0;
    chk("flush1_avail", {7'd0, avail}, 8'h00);
`ifdef FX2_WORD_SOURCE_OVF_EN
    pcinstr = 8'd6; tick(); pcinstr = '0; tick();
    chk_word("ovf_cleared", 8'h00);
    accepted = 1'b1; tick(); accepted = 1'b0;
`endif
    pcinstr = 8'd5; tick(); pcinstr = '0; tick();
    chk_word("flush1_status", 8'h80);
    accepted = 1'b1; tick(); accepted = 1'b0;
    chk("flush1_status_gone", {7'd0, avail}, 8'h00);

    // PING then STATUS while output holds an unaccepted byte and FIFO holds 5
    sample_strobe = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample_data = 8'h50 + 8'(i);
      tick();
    end
    sample_strobe = 1'b0;
    tick();
    pcinstr = 8'd4; tick(); pcinstr = 8'd5; tick(); pcinstr = '0;
    chk_word("ping_hold", 8'h50);
    accepted = 1'b1; tick();
    chk_word("ping_reply", 8'hA5);
    tick();
    chk_word("status_dropped", 8'h51);
    accepted = 1'b0;
    pcinstr = 8'd3; tick(); pcinstr = '0;
    chk("flush2_avail", {7'd0, avail}, 8'h00);

    // 8 buffered: STATUS reports fill 7, then FLUSH
    sample_strobe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample_data = 8'h40 + 8'(i);
      tick();
    end
    sample_strobe = 1'b0;
    tick();
    pcinstr = 8'd5; tick(); pcinstr = '0;
    chk_word("fill_hold", 8'h40);
    accepted = 1'b1; tick();
    chk_word("fill_status", 8'h87);
    tick();
    chk_word("fill_next", 8'h41);
    accepted = 1'b0;
    pcinstr = 8'd3; tick(); pcinstr = '0;
    chk("flush3_avail", {7'd0, avail}, 8'h00);
    pcinstr = 8'd5; tick(); pcinstr = '0; tick();
    chk_word("flush3_status", 8'h80);
    accepted = 1'b1; tick(); accepted = 1'b0;

    // asynchronous reset mid-stream
    sample_strobe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_data = 8'h70 + 8'(i);
      tick();
    end
    sample_strobe = 1'b0;
    tick();
    chk_word("prerst", 8'h70);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_avail", {7'd0, avail}, 8'h00);
    chk("arst_word", word, 8'h00);
    chk("arst_streaming", {7'd0, streaming}, 8'h00);
    tick();
    #3 rst_n = 1'b1;
    tick();
    chk("postrst_avail", {7'd0, avail}, 8'h00);
    pcinstr = 8'd1; tick(); pcinstr = '0;
    sample_strobe = 1'b1; sample_data = 8'h77; tick(); sample_strobe = 1'b0;
    chk("postrst_t1", {7'd0, avail}, 8'h00);
    tick();
    chk_word("postrst_t2", 8'h77);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
